// File: rtl/idiv_iterative.sv
// idiv_iterative
//   Multi-cycle restoring integer divider, signed or unsigned, resolving
//   bits_per_iter_p quotient bits per cycle. It is intended as a
//   long-latency functional unit beside an integer pipeline.
//
//   Ports:
//     clk_i, reset_i         clock (rising edge), async active-high reset
//     v_i / ready_and_o      request handshake (accepted when both high)
//     dividend_i, divisor_i  operands, width_p bits
//     signed_div_i           1 = two's-complement, 0 = unsigned
//     v_o / yumi_i           result handshake (yumi_i only while v_o)
//     quotient_o             quotient, width_p bits
//     remainder_o            remainder, width_p bits
module idiv_iterative #(
   parameter int unsigned width_p         = 32,
   parameter int unsigned bits_per_iter_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_and_o,
   input  logic [width_p-1:0] dividend_i,
   input  logic [width_p-1:0] divisor_i,
   input  logic               signed_div_i,
   output logic [width_p-1:0] quotient_o,
   output logic [width_p-1:0] remainder_o,
   output logic               v_o,
   input  logic               yumi_i
);

   localparam int unsigned ITERS = width_p / bits_per_iter_p;
   localparam int unsigned CNT_W = $clog2(ITERS + 1);
   localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // quo_q starts as the dividend magnitude; its MSBs shift into the
   // partial remainder while quotient bits shift in at the LSB.
   logic [width_p-1:0] quo_q, quo_d;
   logic [width_p:0]   rem_q, rem_d;
   logic [width_p-1:0] dvsr_q, dvsr_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [width_p-1:0] res_quo_q, res_quo_d;
   logic [width_p-1:0] res_rem_q, res_rem_d;

   logic [width_p:0]   iter_rem;
   logic [width_p-1:0] iter_quo;

   assign ready_and_o = (state_q == S_IDLE);
   assign v_o         = (state_q == S_DONE);
   assign quotient_o  = res_quo_q;
   assign remainder_o = res_rem_q;

   // bits_per_iter_p restoring steps chained combinationally, MSB first.
   always_comb begin
      iter_rem = rem_q;
      iter_quo = quo_q;
      for (int unsigned i = 0; i < bits_per_iter_p; i++) begin
         iter_rem = {iter_rem[width_p-1:0], iter_quo[width_p-1]};
         iter_quo = {iter_quo[width_p-2:0], 1'b0};
         if (iter_rem >= {1'b0, dvsr_q}) begin
            iter_rem    = iter_rem - {1'b0, dvsr_q};
            iter_quo[0] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      res_quo_d = res_quo_q;
      res_rem_d = res_rem_q;

      case (state_q)
         S_IDLE: begin
            if (v_i) begin
               quo_d     = (signed_div_i && dividend_i[width_p-1]) ? -dividend_i : dividend_i;
               dvsr_d    = (signed_div_i && divisor_i[width_p-1])  ? -divisor_i  : divisor_i;
               rem_d     = '0;
               neg_quo_d = signed_div_i && (dividend_i[width_p-1] ^ divisor_i[width_p-1]);
               neg_rem_d = signed_div_i && dividend_i[width_p-1];
               div0_d    = (divisor_i == '0);
               cnt_d     = ITERS_C;
               state_d   = S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               rem_d = iter_rem;
               quo_d = iter_quo;
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FIX: begin
            // Divide by zero leaves |dividend| as remainder, so the usual
            // remainder sign fix restores the original dividend; only the
            // quotient needs forcing to all ones.
            res_quo_d = div0_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
            res_rem_d = neg_rem_q ? -rem_q[width_p-1:0] : rem_q[width_p-1:0];
            state_d   = S_DONE;
         end
         S_DONE: begin
            if (yumi_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         res_quo_q <= '0;
         res_rem_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvsr_q    <= dvsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         res_quo_q <= res_quo_d;
         res_rem_q <= res_rem_d;
      end
   end

endmodule

// File: tb/tb_idiv_iterative.sv
module tb_idiv_iterative;

   localparam int unsigned W   = 32;
   localparam int unsigned B   = 2;
   localparam int unsigned LAT = W / B + 2;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         v_i;
   logic         ready_and_o;
   logic [W-1:0] dividend_i;
   logic [W-1:0] divisor_i;
   logic         signed_div_i;
   logic [W-1:0] quotient_o;
   logic [W-1:0] remainder_o;
   logic         v_o;
   logic         yumi_i;
   logic         auto_yumi;
   logic         yumi_man;

   assign yumi_i = auto_yumi ? v_o : yumi_man;

   always #5 clk = ~clk;

   idiv_iterative #(
      .width_p        (W),
      .bits_per_iter_p(B)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .v_i         (v_i),
      .ready_and_o (ready_and_o),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .signed_div_i(signed_div_i),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
      .v_o         (v_o),
      .yumi_i      (yumi_i)
   );

   int checks  = 0;
   int passes  = 0;
   int accepts = 0;
   int results = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference: plain language arithmetic; 64-bit signed math makes the
   // most-negative / -1 case wrap naturally when truncated to W bits.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa;
      longint sb;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit noisy, input int hold,
                         output logic [W-1:0] q, output logic [W-1:0] r);
      int           lat;
      int           n;
      bit           ready_ok;
      logic [W-1:0] q0;
      logic [W-1:0] r0;
      @(negedge clk);
      n = 0;
      while (!ready_and_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_accept", W'(ready_and_o), 1);
      dividend_i   = a;
      divisor_i    = b;
      signed_div_i = s;
      v_i          = 1'b1;
      @(posedge clk);
      accepts++;
      #1;
      v_i      = 1'b0;
      lat      = 0;
      ready_ok = 1'b1;
      while (lat < 100) begin
         if (noisy) begin
            v_i          = 1'($urandom);
            dividend_i   = $urandom;
            divisor_i    = $urandom;
            signed_div_i = 1'($urandom);
         end
         @(posedge clk);
         lat++;
         #1;
         if (v_o) break;
         if (ready_and_o) ready_ok = 1'b0;
      end
      v_i = 1'b0;
      check("latency", W'(lat), W'(LAT));
      check("ready_low_busy", W'(ready_ok), 1);
      q = quotient_o;
      r = remainder_o;
      if (v_o) results++;
      if (hold > 0) begin
         q0 = quotient_o;
         r0 = remainder_o;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_v_o", W'(v_o), 1);
            check("hold_quotient", quotient_o, q0);
            check("hold_remainder", remainder_o, r0);
         end
         yumi_man = 1'b1;
         @(posedge clk);
         #1;
         yumi_man = 1'b0;
      end else begin
         @(posedge clk);
         #1;
      end
      check("ready_after_consume", W'(ready_and_o), 1);
      check("v_o_after_consume", W'(v_o), 0);
   endtask

   initial begin
      vec_t         vecs[9];
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic [W-1:0] a;
      logic [W-1:0] b;

      vecs[0] = '{32'd100,        32'd7,          1'b1, 32'd14,         32'd2};
      vecs[1] = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE};
      vecs[2] = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2};
      vecs[3] = '{32'hFFFFFFFF,   32'd2,          1'b0, 32'h7FFFFFFF,   32'd1};
      vecs[4] = '{32'hFFFFFFFF,   32'd2,          1'b1, 32'd0,          32'hFFFFFFFF};
      vecs[5] = '{32'h80000005,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h80000005};
      vecs[6] = '{32'h80000005,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h80000005};
      vecs[7] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
      vecs[8] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000};

      reset_i      = 1'b1;
      v_i          = 1'b0;
      dividend_i   = '0;
      divisor_i    = '0;
      signed_div_i = 1'b0;
      auto_yumi    = 1'b1;
      yumi_man     = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ready", W'(ready_and_o), 1);
      check("reset_v_o", W'(v_o), 0);
      check("reset_quotient", quotient_o, '0);
      check("reset_remainder", remainder_o, '0);
      reset_i = 1'b0;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, 0, q, r);
         check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
         check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      end

      // DONE held without yumi_i.
      auto_yumi = 1'b0;
      run_op(vecs[1].a, vecs[1].b, vecs[1].s, 1'b0, 5, q, r);
      check("hold_vec_quotient", q, vecs[1].q);
      check("hold_vec_remainder", r, vecs[1].r);
      auto_yumi = 1'b1;

      // Reset during CALC drops the in-flight operation.
      @(negedge clk);
      dividend_i   = 32'd12345;
      divisor_i    = 32'd17;
      signed_div_i = 1'b0;
      v_i          = 1'b1;
      @(posedge clk);
      #1;
      v_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset_i = 1'b1;
      #1;
      check("midreset_v_o", W'(v_o), 0);
      check("midreset_ready", W'(ready_and_o), 1);
      check("midreset_quotient", quotient_o, '0);
      check("midreset_remainder", remainder_o, '0);
      @(negedge clk);
      reset_i = 1'b0;
      run_op(vecs[2].a, vecs[2].b, vecs[2].s, 1'b0, 0, q, r);
      check("postreset_quotient", q, vecs[2].q);
      check("postreset_remainder", r, vecs[2].r);

      // Random pairs, alternating signed/unsigned, inputs churned while busy.
      for (int i = 0; i < 2000; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) a = 32'h80000000;
         if ($urandom_range(0, 15) == 0) b = 32'hFFFFFFFF;
         model(a, b, 1'(i % 2), eq, er);
         run_op(a, b, 1'(i % 2), 1'b1, 0, q, r);
         check($sformatf("rand%0d_quotient", i), q, eq);
         check($sformatf("rand%0d_remainder", i), r, er);
      end

      check("no_lost_requests", W'(results), W'(accepts));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
